// File: rtl/alarm_ring_ctrl.sv
// Alarm register, match FSM and buzzer tone generator for the digital clock.
// Optional hourly chime is compiled in with `define HOURLY_CHIME_EN.
module alarm_ring_ctrl #(
    parameter int TONE_DIV  = 50000,
    parameter int RING_SECS = 60
) (
    input  logic       CLK_50,
    input  logic       nCR,
    input  logic       tick_1hz,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       mode,
    input  logic       sethkey,
    input  logic       setmkey,
    input  logic       CtrRing,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_min,
    output logic       ringing,
    output logic       alarmout
);

    localparam int DW = $clog2(TONE_DIV);
    localparam logic [DW-1:0] LO_LAST = DW'(TONE_DIV - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    typedef enum logic {
        IDLE,
        RING
    } state_t;

    state_t state_q, state_d;
    logic [7:0] ahour_q, ahour_d;
    logic [7:0] amin_q, amin_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [DW-1:0] div_q, div_d, div_last;
    logic tone_q, tone_d;
    logic alarmout_q, alarmout_d;
    logic key_any, match, ring_d, tone_en;

`ifdef HOURLY_CHIME_EN
    localparam logic [DW-1:0] HI_LAST = DW'(TONE_DIV / 2 - 1);
    logic chime_lo, chime_hi;
`endif

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)
            return 8'h00;
        else if (h[3:0] == 4'h9)
            return {h[7:4] + 4'h1, 4'h0};
        else
            return {h[7:4], h[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == 8'h59)
            return 8'h00;
        else if (m[3:0] == 4'h9)
            return {m[7:4] + 4'h1, 4'h0};
        else
            return {m[7:4], m[3:0] + 4'h1};
    endfunction

    assign key_any = sethkey | setmkey;

    always_comb begin
        ahour_d = ahour_q;
        amin_d  = amin_q;
        if (mode) begin
            if (sethkey)
                ahour_d = hour_inc(ahour_q);
            if (setmkey)
                amin_d = min_inc(amin_q);
        end
    end

    // Compare against the stored alarm, not the value being edited this cycle
    assign match = tick_1hz & CtrRing
                 & (hour_bcd == ahour_q)
                 & (min_bcd == amin_q)
                 & (sec_bcd == 8'h00);

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (match && !key_any) begin
                    state_d    = RING;
                    ring_cnt_d = 8'h00;
                end
            end
            RING: begin
                if (key_any || !CtrRing ||
                    (tick_1hz && ring_cnt_q == RING_LAST)) begin
                    state_d    = IDLE;
                    ring_cnt_d = 8'h00;
                end else if (tick_1hz) begin
                    ring_cnt_d = ring_cnt_q + 8'h01;
                end
            end
            default: begin
                state_d    = IDLE;
                ring_cnt_d = 8'h00;
            end
        endcase
    end

    assign ring_d = (state_d == RING);

`ifdef HOURLY_CHIME_EN
    // Chime only in IDLE, so a ringing alarm always wins
    always_comb begin
        chime_lo = 1'b0;
        chime_hi = 1'b0;
        if (!ring_d && min_bcd == 8'h59) begin
            chime_lo = (sec_bcd == 8'h51) || (sec_bcd == 8'h53) ||
                       (sec_bcd == 8'h55) || (sec_bcd == 8'h57);
            chime_hi = (sec_bcd == 8'h59);
        end
    end
    assign tone_en  = ring_d | chime_lo | chime_hi;
    assign div_last = chime_hi ? HI_LAST : LO_LAST;
`else
    assign tone_en  = ring_d;
    assign div_last = LO_LAST;
`endif

    always_comb begin
        div_d  = '0;
        tone_d = 1'b0;
        if (tone_en) begin
            if (div_q >= div_last) begin
                div_d  = '0;
                tone_d = ~tone_q;
            end else begin
                div_d  = div_q + 1'b1;
                tone_d = tone_q;
            end
        end
    end

    always_comb begin
        alarmout_d = tone_d & ring_d & ~ring_cnt_d[0];
`ifdef HOURLY_CHIME_EN
        alarmout_d = alarmout_d | (tone_d & (chime_lo | chime_hi));
`endif
    end

    always_ff @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) begin
            state_q    <= IDLE;
            ahour_q    <= 8'h00;
            amin_q     <= 8'h00;
            ring_cnt_q <= 8'h00;
            div_q      <= '0;
            tone_q     <= 1'b0;
            alarmout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ahour_q    <= ahour_d;
            amin_q     <= amin_d;
            ring_cnt_q <= ring_cnt_d;
            div_q      <= div_d;
            tone_q     <= tone_d;
            alarmout_q <= alarmout_d;
        end
    end

    assign alarm_hour = ahour_q;
    assign alarm_min  = amin_q;
    assign ringing    = (state_q == RING);
    assign alarmout   = alarmout_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with TONE_DIV=4, RING_SECS=3.
module tb_alarm_ring_ctrl;

    logic clk = 1'b0;
    logic nCR = 1'b0;
    logic tick = 1'b0;
    logic mode = 1'b0;
    logic sh = 1'b0;
    logic sm = 1'b0;
    logic ctr = 1'b0;
    logic [7:0] hh = 8'h00;
    logic [7:0] mm = 8'h00;
    logic [7:0] ss = 8'h00;
    logic [7:0] alarm_hour, alarm_min;
    logic ringing, alarmout;
    logic ao_hist [16];
    int total = 0;
    int bad = 0;

    alarm_ring_ctrl #(
        .TONE_DIV(4),
        .RING_SECS(3)
    ) dut (
        .CLK_50(clk),
        .nCR(nCR),
        .tick_1hz(tick),
        .hour_bcd(hh),
        .min_bcd(mm),
        .sec_bcd(ss),
        .mode(mode),
        .sethkey(sh),
        .setmkey(sm),
        .CtrRing(ctr),
        .alarm_hour(alarm_hour),
        .alarm_min(alarm_min),
        .ringing(ringing),
        .alarmout(alarmout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_at(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
        hh = h;
        mm = m;
        ss = s;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic key_h();
        sh = 1'b1;
        cyc();
        sh = 1'b0;
    endtask

    task automatic key_m();
        sm = 1'b1;
        cyc();
        sm = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_hour", alarm_hour, 8'h00);
        chk("rst_min", alarm_min, 8'h00);
        chk("rst_ringing", {7'd0, ringing}, 8'h00);
        chk("rst_alarmout", {7'd0, alarmout}, 8'h00);
        #10;
        nCR = 1'b1;
        cyc(2);

        mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            key_h();
            chk("hour_step", alarm_hour, to_bcd((i + 1) % 24));
        end
        for (int i = 0; i < 60; i++) begin
            key_m();
            chk("min_step", alarm_min, to_bcd((i + 1) % 60));
        end
        chk("min_no_carry", alarm_hour, 8'h00);

        repeat (7) key_h();
        repeat (30) key_m();
        chk("set_hour", alarm_hour, 8'h07);
        chk("set_min", alarm_min, 8'h30);

        mode = 1'b0;
        repeat (5) key_h();
        chk("hour_mode0", alarm_hour, 8'h07);

        ctr = 1'b1;
        tick_at(8'h07, 8'h29, 8'h59);
        chk("no_early_ring", {7'd0, ringing}, 8'h00);
        cyc(2);
        tick_at(8'h07, 8'h30, 8'h00);
        chk("ring_start", {7'd0, ringing}, 8'h01);

        ao_hist[0] = alarmout;
        for (int k = 1; k < 16; k++) begin
            cyc();
            ao_hist[k] = alarmout;
        end
        for (int k = 0; k < 12; k++)
            chk("tone_flip", {7'd0, ao_hist[k + 4]}, {7'd0, ~ao_hist[k]});

        tick_at(8'h07, 8'h30, 8'h01);
        chk("ring_sec1", {7'd0, ringing}, 8'h01);
        for (int k = 0; k < 8; k++) begin
            chk("quiet_sec1", {7'd0, alarmout}, 8'h00);
            cyc();
        end
        tick_at(8'h07, 8'h30, 8'h02);
        chk("ring_sec2", {7'd0, ringing}, 8'h01);
        cyc(3);
        tick_at(8'h07, 8'h30, 8'h03);
        chk("ring_end", {7'd0, ringing}, 8'h00);
        chk("ring_end_ao", {7'd0, alarmout}, 8'h00);

        ctr = 1'b0;
        tick_at(8'h07, 8'h30, 8'h00);
        chk("disarmed", {7'd0, ringing}, 8'h00);
        cyc(2);
        chk("disarmed_later", {7'd0, ringing}, 8'h00);

        ctr = 1'b1;
        tick_at(8'h07, 8'h30, 8'h00);
        chk("rearm", {7'd0, ringing}, 8'h01);
        cyc(2);
        key_m();
        chk("key_stop", {7'd0, ringing}, 8'h00);
        chk("key_stop_ao", {7'd0, alarmout}, 8'h00);
        chk("min_keep", alarm_min, 8'h30);

        tick_at(8'h07, 8'h30, 8'h00);
        chk("ring_again", {7'd0, ringing}, 8'h01);
        ctr = 1'b0;
        cyc();
        chk("ctr_stop", {7'd0, ringing}, 8'h00);
        ctr = 1'b1;

        sh = 1'b1;
        tick_at(8'h07, 8'h30, 8'h00);
        sh = 1'b0;
        chk("key_suppress", {7'd0, ringing}, 8'h00);
        chk("key_suppress_hr", alarm_hour, 8'h07);

        mode = 1'b1;
        sm = 1'b1;
        tick_at(8'h07, 8'h30, 8'h00);
        sm = 1'b0;
        mode = 1'b0;
        chk("edit_suppress", {7'd0, ringing}, 8'h00);
        chk("edit_suppress_min", alarm_min, 8'h31);

        tick_at(8'h07, 8'h31, 8'h00);
        chk("ring_0731", {7'd0, ringing}, 8'h01);
        cyc(5);
        @(posedge clk);
        #2;
        nCR = 1'b0;
        #1;
        chk("mid_rst_hour", alarm_hour, 8'h00);
        chk("mid_rst_min", alarm_min, 8'h00);
        chk("mid_rst_ringing", {7'd0, ringing}, 8'h00);
        chk("mid_rst_ao", {7'd0, alarmout}, 8'h00);
        #3;
        nCR = 1'b1;
        cyc(2);
        chk("post_rst_idle", {7'd0, ringing}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
